// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU fetch/MEM ports, the arbiter and the external bus.
// Modport master is the arbiter's view; slave is the environment (requesters + bus slave).
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // Data port (MEM stage, already lane-translated)
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // External sram-like bus
  logic              bus_req;
  logic              bus_wr;
  logic [3:0]        bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wen, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_wen, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wen, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_wen, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like bus between fetch and data ports, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_bus_arbiter (
  input logic               clk,
  input logic               resetn,
  mem_bus_arbiter_if.master ports
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrI,
    StAddrD,
    StWaitI,
    StWaitD
  } state_e;

  state_e state_q;
  logic   grant_data;

`ifdef ARB_RR_EN
  // 1: data port wins a tie, 0: fetch port wins a tie
  logic ptr_q;
  assign grant_data = ports.data_req & (~ports.inst_req | ptr_q);
`else
  assign grant_data = ports.data_req;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
`ifdef ARB_RR_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_data) begin
            state_q <= StAddrD;
          end else if (ports.inst_req) begin
            state_q <= StAddrI;
          end
        end
        StAddrI: begin
          if (ports.bus_addr_ok) state_q <= StWaitI;
        end
        StAddrD: begin
          if (ports.bus_addr_ok) state_q <= StWaitD;
        end
        StWaitI: begin
          if (ports.bus_data_ok) begin
            state_q <= StIdle;
`ifdef ARB_RR_EN
            ptr_q   <= 1'b1;
`endif
          end
        end
        StWaitD: begin
          if (ports.bus_data_ok) begin
            state_q <= StIdle;
`ifdef ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus fields and handshakes are a pure decode of the owner state, so an
  // asynchronous reset clears every output without waiting for a clock.
  always_comb begin
    ports.bus_req      = 1'b0;
    ports.bus_wr       = 1'b0;
    ports.bus_wen      = '0;
    ports.bus_addr     = '0;
    ports.bus_wdata    = '0;
    ports.inst_addr_ok = 1'b0;
    ports.inst_data_ok = 1'b0;
    ports.inst_rdata   = '0;
    ports.data_addr_ok = 1'b0;
    ports.data_data_ok = 1'b0;
    ports.data_rdata   = '0;
    case (state_q)
      StAddrI: begin
        ports.bus_req      = 1'b1;
        ports.bus_addr     = ports.inst_addr;
        ports.inst_addr_ok = ports.bus_addr_ok;
      end
      StAddrD: begin
        ports.bus_req      = 1'b1;
        ports.bus_wr       = ports.data_wr;
        ports.bus_wen      = ports.data_wen;
        ports.bus_addr     = ports.data_addr;
        ports.bus_wdata    = ports.data_wdata;
        ports.data_addr_ok = ports.bus_addr_ok;
      end
      StWaitI: begin
        ports.inst_data_ok = ports.bus_data_ok;
        if (ports.bus_data_ok) ports.inst_rdata = ports.bus_rdata;
      end
      StWaitD: begin
        ports.data_data_ok = ports.bus_data_ok;
        if (ports.bus_data_ok) ports.data_rdata = ports.bus_rdata;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // Requesters must hold req until their address is accepted.
  assert property (@(posedge clk) disable iff (!resetn)
    (state_q == StAddrI) |-> ports.inst_req);
  assert property (@(posedge clk) disable iff (!resetn)
    (state_q == StAddrD) |-> ports.data_req);
  assert property (@(posedge clk) disable iff (!resetn)
    !(ports.inst_addr_ok && ports.data_addr_ok) && !(ports.inst_data_ok && ports.data_data_ok));
`endif

endmodule
